// File: rtl/timer_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_sched_pkg
// Description : Shared definitions for the multi-channel timer scheduler:
//               channel command encodings and scan FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_sched_pkg;

   // cfg_cmd encodings
   localparam logic [1:0] CMD_NOP      = 2'b00;
   localparam logic [1:0] CMD_ONESHOT  = 2'b01;
   localparam logic [1:0] CMD_PERIODIC = 2'b10;
   localparam logic [1:0] CMD_STOP     = 2'b11;

   // Scan FSM states
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } scan_state_t;

endpackage : timer_sched_pkg
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : timer_prescaler
// Description : Free-running prescaler. The counter wraps to 0 when it equals
//               prescale and a 1-cycle tick is emitted on that cycle, giving a
//               tick period of prescale+1 clk cycles.
// Ports       : clk      - system clock
//               resetn   - asynchronous active-low reset
//               prescale - tick period minus 1, in clk cycles
//               tick     - 1-cycle tick strobe
// Revision    : 1.0 - initial release
// ============================================================================
module timer_prescaler #(
   parameter int PRE_W = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [PRE_W-1:0] prescale,
   output logic             tick
);

   logic [PRE_W-1:0] r_cnt;

   assign tick = (r_cnt == prescale);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt <= '0;
      end else if (tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule : timer_prescaler
`default_nettype wire

// File: rtl/timer_sched.sv
`default_nettype none
// ============================================================================
// Module      : timer_sched
// Description : Multi-channel timer scheduler. A shared prescaler tick starts
//               a scan that services one channel per cycle through a single
//               decrement datapath (decrement, expire, reload).
// Ports       : clk, resetn           - clock, async active-low reset
//               prescale              - tick period minus 1
//               cfg_we/ch/cmd/load    - channel command (nop/oneshot/periodic/stop)
//               irq_en_we/irq_en_d    - IRQ enable write
//               clr_we/clr_mask       - write-1-to-clear of pending
//               rd_ch/rd_count        - combinational count readback
//               active, pending       - per-channel run / expiry flags
//               irq                   - registered OR of pending & irq_en
//               busy                  - scan in progress
//               overrun               - sticky, tick arrived during a scan
//               missed                - (TIMER_SCHED_MISS_EN only) expiry while
//                                       pending was already set
// Options     : `define TIMER_SCHED_MISS_EN adds the missed output.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_sched
   import timer_sched_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 32,
   parameter int PRE_W  = 16
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [PRE_W-1:0]          prescale,
   input  logic                      cfg_we,
   input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
   input  logic [1:0]                cfg_cmd,
   input  logic [CNT_W-1:0]          cfg_load,
   input  logic                      irq_en_we,
   input  logic [NUM_CH-1:0]         irq_en_d,
   input  logic                      clr_we,
   input  logic [NUM_CH-1:0]         clr_mask,
   input  logic [$clog2(NUM_CH)-1:0] rd_ch,
   output logic [CNT_W-1:0]          rd_count,
   output logic [NUM_CH-1:0]         active,
   output logic [NUM_CH-1:0]         pending,
   output logic                      irq,
   output logic                      busy,
   output logic                      overrun
`ifdef TIMER_SCHED_MISS_EN
   ,
   output logic [NUM_CH-1:0]         missed
`endif
);

   localparam int IDX_W = $clog2(NUM_CH);

   logic                tick;
   scan_state_t         r_state, w_state_nxt;
   logic [IDX_W-1:0]    r_idx, w_idx_nxt;

   logic [CNT_W-1:0]    r_count [NUM_CH];
   logic [CNT_W-1:0]    r_load  [NUM_CH];
   logic [NUM_CH-1:0]   r_active, r_periodic, r_pending, r_irq_en;
   logic                r_irq, r_overrun;

   logic [NUM_CH-1:0]   w_cmd, w_svc, w_exp, w_clr;

   timer_prescaler #(.PRE_W(PRE_W)) u_prescaler (
      .clk      (clk),
      .resetn   (resetn),
      .prescale (prescale),
      .tick     (tick)
   );

   // ---------------- scan FSM ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      busy        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (tick) begin
               w_state_nxt = ST_SCAN;
               w_idx_nxt   = '0;
            end
         end
         ST_SCAN: begin
            busy = 1'b1;
            if (r_idx == IDX_W'(NUM_CH - 1)) begin
               w_state_nxt = ST_IDLE;
               w_idx_nxt   = '0;
            end else begin
               w_idx_nxt = r_idx + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
         end
      endcase
   end

   // ---------------- per-channel decode ----------------
   // A real command (not nop) to a channel suppresses that channel's scan
   // update in the same cycle, including any expiry it would have produced.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign w_cmd[i] = cfg_we && (cfg_ch == IDX_W'(i)) && (cfg_cmd != CMD_NOP);
      assign w_svc[i] = (r_state == ST_SCAN) && (r_idx == IDX_W'(i)) && r_active[i];
      assign w_exp[i] = w_svc[i] && !w_cmd[i] && (r_count[i] == '0);
   end

   assign w_clr = clr_we ? clr_mask : '0;

   // ---------------- channel state ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_count[i] <= '0;
            r_load[i]  <= '0;
         end
         r_active   <= '0;
         r_periodic <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_cmd[i]) begin
               if (cfg_cmd == CMD_STOP) begin
                  r_active[i] <= 1'b0;
               end else begin
                  r_load[i]     <= cfg_load;
                  r_count[i]    <= cfg_load;
                  r_active[i]   <= 1'b1;
                  r_periodic[i] <= (cfg_cmd == CMD_PERIODIC);
               end
            end else if (w_svc[i]) begin
               if (r_count[i] != '0) begin
                  r_count[i] <= r_count[i] - 1'b1;
               end else if (r_periodic[i]) begin
                  r_count[i] <= r_load[i];
               end else begin
                  r_active[i] <= 1'b0;
               end
            end
         end
      end
   end

   // ---------------- flags, irq, overrun ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pending <= '0;
         r_irq_en  <= '0;
         r_irq     <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         // set has priority over clear
         r_pending <= (r_pending & ~w_clr) | w_exp;
         if (irq_en_we) begin
            r_irq_en <= irq_en_d;
         end
         r_irq <= |(r_pending & r_irq_en);
         if (tick && (r_state == ST_SCAN)) begin
            r_overrun <= 1'b1;
         end
      end
   end

`ifdef TIMER_SCHED_MISS_EN
   logic [NUM_CH-1:0] r_missed;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_missed <= '0;
      end else begin
         r_missed <= (r_missed & ~w_clr) | (w_exp & r_pending);
      end
   end

   assign missed = r_missed;
`endif

   // ---------------- readback ----------------
   always_comb begin
      rd_count = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd_ch == IDX_W'(i)) begin
            rd_count = r_count[i];
         end
      end
   end

   assign active  = r_active;
   assign pending = r_pending;
   assign irq     = r_irq;
   assign overrun = r_overrun;

endmodule : timer_sched
`default_nettype wire

// File: doc/timer_sched.md
Name: timer_sched

Overview:
- Multi-channel timer scheduler for the SoC timer peripheral.
- One shared prescaler and one shared decrement datapath serve NUM_CH software-visible countdown channels.
- Each prescaler tick starts a scan FSM that services one channel per cycle: decrement, expire, reload.
- Sits behind the AXI-lite register slave; drives per-channel pending flags and a single combined IRQ to the PicoRV32.

Parameters:
- NUM_CH, 4, number of timer channels (2..8).
- CNT_W, 32, channel counter and load width.
- PRE_W, 16, prescaler compare width.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- prescale  in  PRE_W  tick period minus 1, in clk cycles
- cfg_we  in  1  channel command strobe
- cfg_ch  in  $clog2(NUM_CH)  target channel
- cfg_cmd  in  2  00 nop, 01 start one-shot, 10 start periodic, 11 stop
- cfg_load  in  CNT_W  load value captured on start
- irq_en_we  in  1  IRQ enable write strobe
- irq_en_d  in  NUM_CH  IRQ enable write data
- clr_we  in  1  pending clear strobe
- clr_mask  in  NUM_CH  write-1-to-clear mask for pending
- rd_ch  in  $clog2(NUM_CH)  count readback select
- rd_count  out  CNT_W  current count of rd_ch (combinational)
- active  out  NUM_CH  channel running
- pending  out  NUM_CH  expiry flags
- irq  out  1  OR of (pending & irq_en)
- busy  out  1  scan in progress
- overrun  out  1  sticky: tick arrived during scan

Behaviour:
- Reset (async, resetn=0): all counts, loads, active, periodic, pending, irq_en, overrun = 0; prescaler counter = 0; FSM = IDLE; irq = 0; busy = 0.
- Prescaler: counter increments each clk. When it equals prescale, it wraps to 0 and emits a 1-cycle tick. Tick period is prescale+1 cycles; prescale=0 gives a tick every cycle.
- FSM states: IDLE and SCAN.
  - IDLE, tick: go to SCAN with idx=0.
  - SCAN: service channel idx. If idx==NUM_CH-1, go to IDLE, else idx+1.
  - busy=1 in SCAN. A scan lasts exactly NUM_CH cycles.
- Channel service, only when active[idx]:
  - count != 0: count <= count-1.
  - count == 0: expire. Set pending[idx]. If periodic, count <= load; else active <= 0.
- Timing: after a start with load L, the first expiry is on the (L+1)th tick. A periodic channel then expires every L+1 ticks. L=0 periodic expires every tick.
- Commands:
  - Start: load <= cfg_load, count <= cfg_load, active <= 1, periodic per cmd. Restarting a running channel discards its old count.
  - Stop: active <= 0; count holds. Pending is untouched.
  - Nop: no effect.
  - A command to the channel being serviced in the same cycle wins; that channel's scan update is dropped.
- Overrun: a tick arriving while in SCAN is dropped and sets overrun. Overrun is cleared only by reset. Legal configuration requires prescale >= NUM_CH.
- Pending: set and clear in the same cycle for the same bit → set wins.
- irq is registered: it reflects pending/irq_en one cycle after they change.
- Reset mid-scan: immediate return to IDLE, all state cleared.

Optional Feature:
- Macro TIMER_SCHED_MISS_EN.
- Defined: adds output missed[NUM_CH]. A bit sets when its channel expires while pending is already 1, and clears with the same clr_we/clr_mask write.
- Undefined: no port, no logic.

Decomposition:
- Package timer_sched_pkg:
  - cfg_cmd encodings CMD_NOP, CMD_ONESHOT, CMD_PERIODIC, CMD_STOP
  - FSM state typedef ST_IDLE, ST_SCAN
- Sub-module timer_prescaler (prescale, tick output), instantiated once.

Test Plan:
- Setup for every scenario unless stated: NUM_CH=4, prescale=9 (tick every 10 cycles).
- Ch0 one-shot L=3 → pending[0] sets on 4th tick, active[0]=0 afterwards; no further set after clearing.
- Ch1 periodic L=1 with irq_en=0010 → pending[1] sets every 2 ticks; irq asserts 1 cycle after the set; clr_mask=0010 on the same cycle as a re-expiry leaves pending[1]=1.
- Ch2 periodic L=5, stop after 2 ticks, then restart one-shot L=0 → no expiry while stopped; expiry on the next tick after restart.
- Command to ch3 on the exact cycle ch3 is serviced (cycle 3 of scan) → count equals cfg_load, not cfg_load-1.
- prescale=2 (tick every 3 cycles, shorter than the 4-cycle scan) → overrun=1 after the first scan; remains set until resetn pulse.
- With TIMER_SCHED_MISS_EN, ch0 periodic L=0 and no clear → missed[0]=1 on 2nd tick; clr_mask=0001 clears both pending[0] and missed[0].
